hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS datapath. It detects load-use hazards between the ID stage and the ID/EX pipeline register, and resolves taken branches signalled from the EX/MEM register. It drives the write-enables and flush controls for PC, IF/ID, ID/EX and EX/MEM, and keeps saturating stall/flush event counters for debug.

---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush controller for a
// 5-stage MIPS pipeline, with saturating stall/flush debug counters.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   id_rs/id_rt/...    register fields of the instruction in ID
//   ex_mem_read/ex_rt  load indication and destination held in ID/EX
//   mem_branch/zero    branch resolution held in EX/MEM
//   mem_wait           memory not ready, freezes the pipeline
//   pc_write ...       combinational (Mealy) pipeline register controls
//   state              current FSM state (debug)
//   stall_cnt/flush_cnt saturating event counters
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALLED = 2'd1,
        FLUSHED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   stall_inc;
    logic   flush_inc;
    logic   load_use;
    logic   taken;
    logic   in_run;

    // Hazard detection; $0 never creates a dependency.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign taken    = mem_branch && mem_zero;

    // Unused encoding 3 behaves as RUN.
    assign in_run   = (state_q != STALLED) && (state_q != FLUSHED);

    assign state    = 2'(state_q);

    // State register and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Next state and pipeline controls; priority rst > mem_wait > taken > load_use.
    always_comb begin
        state_d       = state_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_write      = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;

        if (rst) begin
            state_d     = RUN;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_wait) begin
            // Frozen pipeline keeps hazard inputs stable; re-evaluated later.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (taken) begin
            state_d       = FLUSHED;
            flush_inc     = 1'b1;
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
        end else if (load_use && in_run) begin
            state_d     = STALLED;
            stall_inc   = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            // STALLED/FLUSHED mask detection for one cycle, then resume.
            state_d = RUN;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second CNT_W=2 instance checks saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_wait;
    logic        pc_write, pc_sel_branch, ifid_write, ifid_flush;
    logic        idex_bubble, idex_flush, exmem_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        d2_pc_write, d2_pc_sel_branch, d2_ifid_write, d2_ifid_flush;
    logic        d2_idex_bubble, d2_idex_flush, d2_exmem_flush;
    logic [1:0]  d2_state;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    int total = 0;
    int bad   = 0;

    // Control vector order: pc_write, pc_sel_branch, ifid_write, ifid_flush,
    // idex_bubble, idex_flush, exmem_flush.
    localparam logic [6:0] C_NORM  = 7'b1010000;
    localparam logic [6:0] C_STALL = 7'b0000100;
    localparam logic [6:0] C_FLUSH = 7'b1111011;
    localparam logic [6:0] C_WAIT  = 7'b0000000;
    localparam logic [6:0] C_RST   = 7'b0001011;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_wait(mem_wait),
        .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_wait(mem_wait),
        .pc_write(d2_pc_write), .pc_sel_branch(d2_pc_sel_branch),
        .ifid_write(d2_ifid_write), .ifid_flush(d2_ifid_flush),
        .idex_bubble(d2_idex_bubble), .idex_flush(d2_idex_flush),
        .exmem_flush(d2_exmem_flush), .state(d2_state),
        .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic mr, input logic [4:0] ert,
                         input logic br, input logic z, input logic w);
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rt = ert;
        mem_branch = br; mem_zero = z; mem_wait = w;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ctrl(input string tag, input logic [6:0] exp);
        check(tag, 32'({pc_write, pc_sel_branch, ifid_write, ifid_flush,
                        idex_bubble, idex_flush, exmem_flush}), 32'(exp));
    endtask

    task automatic regs(input string tag, input logic [1:0] st,
                        input int sc, input int fc);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".stall"}, 32'(stall_cnt), 32'(sc));
        check({tag, ".flush"}, 32'(flush_cnt), 32'(fc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a load-use present: reset controls win, no bubble.
        rst = 1'b1;
        drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        ctrl("rst_ctrl", C_RST);
        tick();
        regs("rst", 2'd0, 0, 0);
        rst = 1'b0;
        idle();
        ctrl("idle", C_NORM);

        // lw $2 followed by a consumer of $2 in rs.
        drive(5'd2, 5'd7, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        ctrl("lu_rs", C_STALL);
        tick();
        regs("lu_rs", 2'd1, 1, 0);
        #1 ctrl("stalled_masked", C_NORM);
        tick();
        check("stalled_to_run", 32'(state), 32'd0);

        // Non-hazard patterns.
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        ctrl("zero_reg", C_NORM);
        drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        ctrl("rt_unused", C_NORM);
        drive(5'd2, 5'd2, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
        ctrl("no_load", C_NORM);
        drive(5'd5, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        ctrl("lu_rt_nottaken", C_STALL);
        tick();
        regs("lu_rt", 2'd1, 2, 0);
        idle();
        tick();

        // Taken branch with simultaneous load-use: flush wins.
        drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        ctrl("taken_vs_lu", C_FLUSH);
        tick();
        regs("taken", 2'd2, 2, 1);
        drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        ctrl("flushed_masked", C_NORM);
        tick();
        check("flushed_to_run", 32'(state), 32'd0);

        // mem_wait freezes for 3 cycles, then the stall happens once.
        for (int i = 0; i < 3; i++) begin
            drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
            ctrl("wait_ctrl", C_WAIT);
            tick();
            regs("wait", 2'd0, 2, 1);
        end
        drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        ctrl("wait_release", C_STALL);
        tick();
        regs("wait_rel", 2'd1, 3, 1);
        check("sat_d2_at3", 32'(d2_stall_cnt), 32'd3);
        idle();
        tick();

        // Taken branch while STALLED.
        drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        ctrl("lu_again", C_STALL);
        tick();
        regs("lu_again", 2'd1, 4, 1);
        drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        ctrl("taken_in_stall", C_FLUSH);
        tick();
        regs("taken_in_stall", 2'd2, 4, 2);
        check("sat_d2_hold", 32'(d2_stall_cnt), 32'd3);
        check("d2_flush", 32'(d2_flush_cnt), 32'd2);
        idle();
        tick();

        // One more stall: narrow counter stays saturated.
        drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        tick();
        regs("lu5", 2'd1, 5, 2);
        check("sat_d2_final", 32'(d2_stall_cnt), 32'd3);

        // Reset while STALLED aborts everything.
        rst = 1'b1;
        #1 ctrl("rst_mid_ctrl", C_RST);
        tick();
        regs("rst_mid", 2'd0, 0, 0);
        check("rst_mid_d2", 32'(d2_stall_cnt), 32'd0);
        rst = 1'b0;
        idle();
        ctrl("post_rst", C_NORM);
        tick();
        check("post_rst_state", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
